// File: rtl/rr_plogb_beat_scheduler.sv
// Packs variable-length logb records bit-contiguously into fixed-width trace beats, queues them
// in a FWFT FIFO, drives almful back-pressure and sequences the end-of-record flush.
module rr_plogb_beat_scheduler #(
    parameter int IN_WIDTH       = 256,
    parameter int OUT_WIDTH      = 512,
    parameter int LEN_WIDTH      = $clog2(IN_WIDTH + 1),
    parameter int FIFO_DEPTH     = 16,
    parameter int ALMFUL_SLACK   = 8,
    parameter int QUIESCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [LEN_WIDTH-1:0] in_len,
    output logic                 almful,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    input  logic                 out_ready,
    input  logic                 flush_req,
    output logic                 flush_busy,
    output logic                 flush_done,
    output logic [31:0]          beat_cnt,
    output logic                 overflow_err,
    output logic [2:0]           flush_state
);

    localparam int SUM_W = $clog2(2 * OUT_WIDTH);
    localparam int RL_W  = $clog2(OUT_WIDTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int QC_W  = (QUIESCE_CYCLES > 0) ? $clog2(QUIESCE_CYCLES + 1) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_QUIESCE = 3'd1;
    localparam logic [2:0] S_PAD     = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    if (IN_WIDTH > OUT_WIDTH) begin : g_bad_width
        $error("IN_WIDTH must not exceed OUT_WIDTH");
    end
    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 4");
    end
    if (ALMFUL_SLACK >= FIFO_DEPTH) begin : g_bad_slack
        $error("ALMFUL_SLACK must be less than FIFO_DEPTH");
    end

    logic [RL_W-1:0]        res_len;
    logic [OUT_WIDTH-1:0]   res_data;
    logic [IN_WIDTH-1:0]    rec_mask;
    logic [IN_WIDTH-1:0]    rec;
    logic [SUM_W-1:0]       sum;
    logic [2*OUT_WIDTH-1:0] merged;
    logic                   accept;
    logic                   acc_full;

    logic [2:0]             state;
    logic [QC_W-1:0]        qcnt;
    logic                   pad_fire;
    logic                   pad_push;

    logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic                   fifo_full;
    logic                   push;
    logic                   push_ok;
    logic                   pop;
    logic [OUT_WIDTH-1:0]   push_data;

    always_comb begin
        rec_mask = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            rec_mask[i] = (in_len > LEN_WIDTH'(i));
        end
    end

    // The residue is kept zero above res_len, so an OR merges the new record in place and the
    // upper half of the double-width merge is exactly the carry-over into the next beat.
    assign rec      = in_data & rec_mask;
    assign accept   = in_valid && (in_len != '0);
    assign sum      = SUM_W'(res_len) + SUM_W'(in_len);
    assign merged   = {{OUT_WIDTH{1'b0}}, res_data} | ((2 * OUT_WIDTH)'(rec) << res_len);
    assign acc_full = accept && (sum >= SUM_W'(OUT_WIDTH));

    // Handshake: a beat moves downstream in every cycle where out_valid and out_ready are both
    // high; out_valid never depends on out_ready.
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign out_valid  = (count != '0);
    assign out_data   = mem[rd_ptr];
    assign pop        = out_valid && out_ready;
    assign pad_fire   = (state == S_PAD) && !in_valid && (!fifo_full || pop);
    assign pad_push   = pad_fire && (res_len != '0);
    assign push       = acc_full || pad_push;
    assign push_data  = acc_full ? merged[OUT_WIDTH-1:0] : res_data;
    assign push_ok    = push && (!fifo_full || pop);
    assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            res_len  <= '0;
            res_data <= '0;
        end else if (accept) begin
            if (acc_full) begin
                res_data <= merged[2*OUT_WIDTH-1:OUT_WIDTH];
                res_len  <= RL_W'(sum - SUM_W'(OUT_WIDTH));
            end else begin
                res_data <= merged[OUT_WIDTH-1:0];
                res_len  <= RL_W'(sum);
            end
        end else if (pad_push) begin
            res_data <= '0;
            res_len  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            almful       <= 1'b0;
            beat_cnt     <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= beat_cnt + 32'd1;
            end
            count  <= count_next;
            almful <= (count_next >= CNT_W'(FIFO_DEPTH - ALMFUL_SLACK));
            if (push && !push_ok) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            qcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush_req) begin
                        state <= S_QUIESCE;
                        qcnt  <= QC_W'(QUIESCE_CYCLES);
                    end
                end
                S_QUIESCE: begin
                    if (qcnt == '0) state <= S_PAD;
                    else            qcnt  <= qcnt - 1'b1;
                end
                S_PAD:   if (pad_fire) state <= S_DRAIN;
                S_DRAIN: if (count == '0) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign flush_busy  = (state != S_IDLE);
    assign flush_done  = (state == S_DONE);
    assign flush_state = state;

endmodule
